// File: rtl/warmboot_pkg.sv
// rtl/warmboot_pkg.sv - shared types and constants for the warm-boot sequencer
// No ports. Provides the FSM state type, grant source codes, image numbers
// and the counter sizing helpers used by warmboot_ctrl and button_debounce.
package warmboot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_USB  = 2'd1;
  localparam logic [1:0] SRC_SW   = 2'd2;
  localparam logic [1:0] SRC_BTN  = 2'd3;

  localparam logic [1:0] IMG_FIRSTBOOT = 2'd0;
  localparam logic [1:0] IMG_DFU       = 2'd1;
  localparam logic [1:0] IMG_APP       = 2'd2;

  // Width able to hold 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // A settle period of 0 behaves like 1, so the load value floors at 0.
  function automatic int settle_load(input int n);
    return (n < 1) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchronizer plus stable-count filter
// Ports:
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   button  in   raw asynchronous button level
//   level   out  debounced level (0 after reset)
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd48000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level
);
  import warmboot_pkg::*;

  localparam int CW = cnt_width(int'(DEBOUNCE_CYCLES));

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          stable_done;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle that the
  // synchronized input disagrees with it.
  assign stable_done = (int'(cnt) + 1) >= int'(DEBOUNCE_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= button;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (stable_done) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/warmboot_ctrl.sv
// rtl/warmboot_ctrl.sv - request arbiter and sequencer for SB_WARMBOOT
// Ports:
//   clk             in   system clock
//   rst             in   synchronous, active-high reset
//   usb_detach_req  in   one-cycle pulse, requests the DFU image
//   sw_req          in   one-cycle CSR write strobe
//   sw_image        in   image for sw_req, sampled with it
//   pin_button_up   in   raw asynchronous button (used only with WARMBOOT_BUTTON_EN)
//   wb_s1, wb_s0    out  image select to SB_WARMBOOT
//   wb_boot         out  BOOT to SB_WARMBOOT, sticky until rst
//   busy            out  a request has been granted
//   granted_src     out  0 none, 1 usb, 2 sw, 3 button
// Build option: define WARMBOOT_BUTTON_EN to build the long-press button path.
module warmboot_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES  = 16'd48000,
  parameter logic [23:0] LONGPRESS_CYCLES = 24'd6000000,
  parameter logic [7:0]  SETTLE_CYCLES    = 8'd16,
  parameter logic [1:0]  BUTTON_IMAGE     = 2'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_detach_req,
  input  logic       sw_req,
  input  logic [1:0] sw_image,
  input  logic       pin_button_up,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot,
  output logic       busy,
  output logic [1:0] granted_src
);
  import warmboot_pkg::*;

  localparam int              SW          = cnt_width(int'(SETTLE_CYCLES));
  localparam logic [SW-1:0]   SETTLE_LOAD = SW'(settle_load(int'(SETTLE_CYCLES)));

  logic btn_req;

`ifdef WARMBOOT_BUTTON_EN
  localparam int LW = cnt_width(int'(LONGPRESS_CYCLES));

  logic          btn_level;
  logic [LW-1:0] lp_cnt;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .button(pin_button_up),
    .level (btn_level)
  );

  // Saturating hold counter; the pulse fires on the step into saturation,
  // so a single press can raise at most one request.
  always_ff @(posedge clk) begin
    if (rst || !btn_level) begin
      lp_cnt  <= '0;
      btn_req <= 1'b0;
    end else begin
      btn_req <= (int'(lp_cnt) + 1) == int'(LONGPRESS_CYCLES);
      if (int'(lp_cnt) < int'(LONGPRESS_CYCLES)) begin
        lp_cnt <= lp_cnt + LW'(1);
      end
    end
  end
`else
  localparam int unused_params = int'(DEBOUNCE_CYCLES) + int'(LONGPRESS_CYCLES);
  logic unused_button;

  assign unused_button = pin_button_up;
  assign btn_req       = 1'b0;
`endif

  state_t        state_q;
  state_t        state_d;
  logic [SW-1:0] settle_q;
  logic [1:0]    img_q;
  logic [1:0]    src_q;

  logic          req_valid;
  logic [1:0]    req_img;
  logic [1:0]    req_src;

  logic [1:0]    img_o;
  logic [1:0]    src_o;
  logic          busy_o;
  logic          boot_o;

  // State, latched grant and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      img_q       <= IMG_FIRSTBOOT;
      src_q       <= SRC_NONE;
      wb_s1       <= 1'b0;
      wb_s0       <= 1'b0;
      wb_boot     <= 1'b0;
      busy        <= 1'b0;
      granted_src <= SRC_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        img_q    <= req_img;
        src_q    <= req_src;
        settle_q <= SETTLE_LOAD;
      end else if (state_q == ST_ARM && settle_q != '0) begin
        settle_q <= settle_q - SW'(1);
      end
      {wb_s1, wb_s0} <= img_o;
      wb_boot        <= boot_o;
      busy           <= busy_o;
      granted_src    <= src_o;
    end
  end

  // Fixed-priority arbitration and next state.
  always_comb begin
    req_valid = 1'b0;
    req_img   = IMG_FIRSTBOOT;
    req_src   = SRC_NONE;
    if (usb_detach_req) begin
      req_valid = 1'b1;
      req_img   = IMG_DFU;
      req_src   = SRC_USB;
    end else if (sw_req) begin
      req_valid = 1'b1;
      req_img   = sw_image;
      req_src   = SRC_SW;
    end else if (btn_req) begin
      req_valid = 1'b1;
      req_img   = BUTTON_IMAGE;
      req_src   = SRC_BTN;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_ARM;
      ST_ARM:  if (settle_q == '0) state_d = ST_FIRE;
      ST_FIRE: state_d = ST_FIRE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so the registered pins
  // line up with the state they describe. On the grant edge the latched
  // image is not yet valid, so the arbitration result is used directly.
  always_comb begin
    img_o  = IMG_FIRSTBOOT;
    src_o  = SRC_NONE;
    busy_o = 1'b0;
    boot_o = 1'b0;
    if (state_d != ST_IDLE) begin
      busy_o = 1'b1;
      img_o  = (state_q == ST_IDLE) ? req_img : img_q;
      src_o  = (state_q == ST_IDLE) ? req_src : src_q;
      boot_o = (state_d == ST_FIRE);
    end
  end

endmodule

// File: doc/warmboot_ctrl.md
# warmboot_ctrl

Sequencer and arbiter for the iCE40 SB_WARMBOOT primitive in the application image. It collects reboot requests from the USB DFU-detach path, the software CSR and an optional front-panel long-press, grants one by fixed priority, and holds the image select stable for a settle period. It then asserts BOOT and never releases it. It sits beside the top-level SoC glue and drives the only SB_WARMBOOT instance in the design.

## Interface
- DEBOUNCE_CYCLES, 16'd48000: cycles the button input must be stable before its debounced level changes.
- LONGPRESS_CYCLES, 24'd6000000: cycles the debounced button must stay pressed to raise a request.
- SETTLE_CYCLES, 8'd16: cycles S1/S0 are held before BOOT asserts.
- BUTTON_IMAGE, 2'd1: image the long-press selects (DFU bootloader).
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- usb_detach_req  in  1  single-cycle pulse; requests image 1
- sw_req  in  1  single-cycle pulse from the CSR write strobe
- sw_image  in  2  image for sw_req, sampled with it
- pin_button_up  in  1  raw, asynchronous, active-high button
- wb_s1  out  1  SB_WARMBOOT S1
- wb_s0  out  1  SB_WARMBOOT S0
- wb_boot  out  1  SB_WARMBOOT BOOT
- busy  out  1  a request has been granted; further requests are ignored
- granted_src  out  2  0 none, 1 usb, 2 sw, 3 button

## Operation
- States: IDLE, ARM, FIRE.
- IDLE:
  - Any request latches the winning image and source, loads the settle counter with SETTLE_CYCLES-1, and moves to ARM on the next edge.
  - Priority is usb_detach_req > sw_req > button request. The lower-priority requests in the same cycle are dropped.
- ARM:
  - {wb_s1,wb_s0} = latched image and busy = 1.
  - The counter decrements each cycle. When it reaches 0, the block moves to FIRE.
  - Requests are ignored.
- FIRE:
  - wb_boot = 1, held until reset or reconfiguration. There is no exit except rst.
- Button path:
  - Two-flop synchronizer, then the debouncer.
  - The long-press counter increments while the debounced level is high and saturates at LONGPRESS_CYCLES.
  - When it reaches LONGPRESS_CYCLES it emits a one-cycle request, only once per press.
  - The counter clears when the debounced level goes low.
- Images 0–3 are all legal for sw_image. Image 0 reboots into the first-stage selector.
- Counter widths are $clog2(param+1). Counters never wrap: the settle counter stops at 0 and the long-press counter saturates.

## Timing
- Reset values:
  - wb_s1=0, wb_s0=0, wb_boot=0, busy=0, granted_src=0.
  - State IDLE, all counters 0, debounced level 0.
- Request pulse at cycle N: busy=1 and S1/S0 valid at N+1. wb_boot=1 at N+1+SETTLE_CYCLES.
- SETTLE_CYCLES=0 is treated as 1. BOOT never rises in the same cycle as S1/S0 change.
- All outputs are registered.
- Button latency from a raw press to the request pulse is 2 + DEBOUNCE_CYCLES + LONGPRESS_CYCLES cycles, ±1.
- rst in ARM or FIRE returns to IDLE with all outputs at their reset values the next cycle. A request in the same cycle as rst is lost.
- A request arriving exactly as ARM exits to FIRE is ignored.

## Configuration
- WARMBOOT_BUTTON_EN defined: the synchronizer, debouncer and long-press path are built, and granted_src=3 is reachable.
- WARMBOOT_BUTTON_EN undefined:
  - pin_button_up remains a port but is unused.
  - The button request is tied to 0 and no debouncer is instantiated.
  - The USB and software paths are unchanged.

## Structure
- Shared package warmboot_pkg:
  - State encoding.
  - Source codes SRC_NONE/SRC_USB/SRC_SW/SRC_BTN.
  - Image constants IMG_FIRSTBOOT=0, IMG_DFU=1, IMG_APP=2.
- One sub-module, button_debounce: synchronizer plus stable-count filter, parameterized by DEBOUNCE_CYCLES, outputting the debounced level. It is instantiated only under WARMBOOT_BUTTON_EN.

## Test plan
- Reset, then sw_req with sw_image=2 at cycle 10, SETTLE_CYCLES=16 -> busy=1 and {s1,s0}=10 at cycle 11; wb_boot=1 at cycle 27 and stays high for 100 cycles.
- usb_detach_req and sw_req (image 3) in the same cycle -> granted_src=1, {s1,s0}=01.
- In ARM, a second sw_req with image 0 -> image unchanged, FIRE timing unchanged.
- Build with WARMBOOT_BUTTON_EN, DEBOUNCE=4, LONGPRESS=20; a 3-cycle glitch produces no request. A sustained press produces one request about 26 cycles later, {s1,s0}=01, granted_src=3. Holding the button longer produces no second request.
- rst asserted mid-ARM and then in FIRE -> all outputs return to 0 the next cycle; a new request afterwards is granted normally.
- Build without WARMBOOT_BUTTON_EN; hold the button for 10^7 cycles -> busy stays 0.
